// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Multi-port register file with two write ports, NRD
//                combinational read ports, optional write-to-read forwarding,
//                and a sequenced clear that zeroes one entry per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                clr_req,
  output logic                busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] c_FIRST_PTR = AW'(1);
  localparam logic [AW-1:0] c_LAST_PTR  = AW'(NREGS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   w_ptr_nxt;
  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wr0;
  logic            w_wr1;

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  assign w_wr0 = (r_state == ST_IDLE) && rst_n && we0 && (wa0 != '0);
  assign w_wr1 = (r_state == ST_IDLE) && rst_n && we1 && (wa1 != '0);
  assign busy  = (r_state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= c_FIRST_PTR;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = c_FIRST_PTR;
        end
      end
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + AW'(1);
        if (r_ptr == c_LAST_PTR) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = c_FIRST_PTR;
      end
    endcase
  end

  // Storage has no reset of its own; only the clear walk zeroes it.
  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else begin
        if (w_wr0) r_mem[wa0] <= wd0;
        if (w_wr1) r_mem[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;

    assign w_ra = ra[k*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
      if (busy || (w_ra == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && w_wr1 && (wa1 == w_ra)) begin
        w_rd = wd1;
      end else if ((BYPASS != 0) && w_wr0 && (wa0 == w_ra)) begin
        w_rd = wd0;
      end
    end

    assign rd[k*XLEN +: XLEN] = w_rd;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Scoreboard bench for reg_file_mp, forwarding and
//                non-forwarding instances driven from one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n, we0, we1, clr_req;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd_bp, rd_nb;
  logic                busy_bp, busy_nb;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra(ra), .rd(rd_bp), .clr_req(clr_req), .busy(busy_bp));

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra(ra), .rd(rd_nb), .clr_req(clr_req), .busy(busy_nb));

  // Reference model state
  logic [XLEN-1:0] m_mem [NREGS];
  logic            m_busy;
  logic [AW-1:0]   m_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_step  = 0;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] val;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit bp);
    if (m_busy || a == '0) return '0;
    if (bp && rst_n && we1 && wa1 == a) return wd1;
    if (bp && rst_n && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic void push(input string tag, input logic [XLEN-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endfunction

  // One clock cycle: predict, sample at negedge, compare, advance model.
  task automatic step();
    exp_t            e;
    logic [XLEN-1:0] obs [6];
    push("busy",    {31'b0, m_busy});
    push("rd0",     exp_rd(ra[0 +: AW], 1'b1));
    push("rd1",     exp_rd(ra[AW +: AW], 1'b1));
    push("busy_nb", {31'b0, m_busy});
    push("rd0_nb",  exp_rd(ra[0 +: AW], 1'b0));
    push("rd1_nb",  exp_rd(ra[AW +: AW], 1'b0));
    @(negedge clk);
    obs[0] = {31'b0, busy_bp};
    obs[1] = rd_bp[0 +: XLEN];
    obs[2] = rd_bp[XLEN +: XLEN];
    obs[3] = {31'b0, busy_nb};
    obs[4] = rd_nb[0 +: XLEN];
    obs[5] = rd_nb[XLEN +: XLEN];
    for (int i = 0; i < 6; i++) begin
      e = sbq.pop_front();
      n_tests++;
      assert (obs[i] === e.val) else begin
        n_fail++;
        $error("FAIL %s step=%0d observed=%h expected=%h", e.tag, n_step, obs[i], e.val);
      end
    end
    if (!rst_n) begin
      m_busy = 1'b1;
      m_ptr  = AW'(1);
    end else if (m_busy) begin
      m_mem[m_ptr] = '0;
      if (m_ptr == AW'(NREGS - 1)) m_busy = 1'b0;
      m_ptr = m_ptr + AW'(1);
    end else begin
      if (we0 && wa0 != '0) m_mem[wa0] = wd0;
      if (we1 && wa1 != '0) m_mem[wa1] = wd1;
      if (clr_req) begin
        m_busy = 1'b1;
        m_ptr  = AW'(1);
      end
    end
    @(posedge clk);
    #1;
    n_step++;
  endtask

  task automatic set_ra(input int a0, input int a1);
    ra = {AW'(a1), AW'(a0)};
  endtask

  task automatic quiet();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0; rst_n = 1'b1;
  endtask

  task automatic noise();
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    wa0 = AW'($urandom_range(0, NREGS - 1));
    wa1 = AW'($urandom_range(0, NREGS - 1));
    wd0 = $urandom;
    wd1 = $urandom;
    set_ra($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
  endtask

  task automatic readback_all();
    quiet();
    for (int i = 0; i < NREGS / 2; i++) begin
      set_ra(2 * i, 2 * i + 1);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
    @(posedge clk);
    #1;
    m_busy = 1'b1;
    m_ptr  = AW'(1);

    // Reset held low for three cycles in total, then the 31-cycle clear
    step();
    step();
    rst_n = 1'b1;
    repeat (NREGS - 1) begin
      noise();
      step();
    end
    readback_all();

    // Single write with same-cycle read
    we0 = 1'b1; wa0 = AW'(5); wd0 = 32'hDEADBEEF; set_ra(5, 5);
    step();
    we0 = 1'b0;
    step();

    // Write collision: port 1 wins
    we0 = 1'b1; wa0 = AW'(7); wd0 = 32'h11;
    we1 = 1'b1; wa1 = AW'(7); wd1 = 32'h22; set_ra(7, 5);
    step();
    quiet();
    step();

    // Writes to register 0 are discarded
    we1 = 1'b1; wa1 = '0; wd1 = 32'hFFFFFFFF; set_ra(0, 7);
    step();
    quiet();
    step();

    // Load random contents
    for (int i = 0; i < 12; i++) begin
      noise();
      step();
    end
    quiet();

    // Clear request with a simultaneous write, repeated request while busy
    clr_req = 1'b1; we0 = 1'b1; wa0 = AW'(3); wd0 = 32'h55; set_ra(3, 7);
    step();
    quiet();
    set_ra(3, 7);
    step();
    for (int i = 0; i < NREGS - 2; i++) begin
      noise();
      clr_req = (i == 10);
      step();
    end
    readback_all();

    // Reset asserted mid-clear when the pointer reaches 20
    for (int i = 0; i < 8; i++) begin
      noise();
      step();
    end
    quiet();
    clr_req = 1'b1;
    step();
    quiet();
    for (int i = 1; i < 20; i++) begin
      noise();
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (NREGS - 1) begin
      noise();
      step();
    end
    readback_all();

    // Mixed traffic after recovery
    for (int i = 0; i < 24; i++) begin
      noise();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
